uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//   Parametrised UART transmitter: next generation of the UART controller TX path.
//   - Single clock; internal baud-tick generator replaces the external bclk.
//   - Adds a byte FIFO with valid/ready input, configurable data width, parity and stop bits.
//   - Sits between the host-side byte source and the txd pin.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per serial bit (>=2)
//   DATA_W        8   data bits per frame (5..9), sent LSB first
//   PARITY        0   0 = none, 1 = even, 2 = odd
//   STOP_BITS     1   number of stop bits (1 or 2)
//   FIFO_DEPTH    4   FIFO entries, power of two (>=2)
// PORTS
//   clk        in   1                       system clock, all logic on posedge
//   rst_n      in   1                       asynchronous, active-low reset
//   din        in   DATA_W                  byte to transmit
//   din_valid  in   1                       din holds a byte to enqueue
//   din_ready  out  1                       FIFO can accept; transfer when valid&&ready at posedge
//   txd        out  1                       serial output, idle high
//   busy       out  1                       1 while FIFO non-empty or a frame is in flight
//   fifo_level out  $clog2(FIFO_DEPTH)+1    FIFO entries currently held
// BEHAVIOUR
//   Reset (async assert, sync release): txd=1, din_ready=1, busy=0, fifo_level=0.
//     FSM=IDLE, FIFO emptied, baud and bit counters cleared.
//     Mid-frame reset drops txd to idle high immediately and discards all queued data.
//   FIFO:
//     - din_ready = !full, registered; no same-cycle bypass when full.
//     - Simultaneous push and pop: level unchanged, both take effect.
//     - Read/write pointers wrap modulo FIFO_DEPTH.
//     - din_valid while !din_ready is ignored; the byte is not latched.
//   FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
//     IDLE:   txd=1; if FIFO non-empty, pop into shift reg, load parity, go START.
//     START:  txd=0 for CLKS_PER_BIT cycles.
//     DATA:   txd=shreg[0]; shift right each bit period; DATA_W bits.
//             Bit counter width $clog2(DATA_W).
//     PARITY: only if PARITY!=0; txd = ^data (even) or ~^data (odd).
//             Parity computed at pop, not from the shifting register.
//     STOP:   txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
//             At the last cycle: if FIFO non-empty, pop and go START directly
//             (zero idle gap); otherwise go IDLE.
//   Bit timing:
//     - Baud counter counts 0..CLKS_PER_BIT-1 and restarts on every state entry.
//     - Every bit is exactly CLKS_PER_BIT cycles.
//     - Frame = (1 + DATA_W + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
//   Latency: byte accepted at edge N into empty FIFO with FSM IDLE -> txd=0 from edge N+1.
//   busy = (state!=IDLE) || (fifo_level!=0). It deasserts on the edge the FSM returns to IDLE.
//   txd is driven from a flop; it never glitches between bit boundaries.
// STRUCTURE
//   uart_pkg:
//     - FSM state localparams (IDLE, START, DATA, PARITY, STOP)
//     - parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD)
//     - START_BIT=0, STOP_BIT=1
//   Sub-module sync_fifo: generic DATA_W x FIFO_DEPTH, push/pop/full/empty/level.
//     The RX path will reuse it.
//   Baud counter and FSM stay in this module.
// TESTING
//   1. 8N1, CLKS_PER_BIT=4, send 0xA5.
//      -> txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy low 40 cycles after accept.
//   2. 8E1, send 0xA5 then 0x01 back to back.
//      -> parity bits 0 then 1; second start bit immediately follows first stop bit, no gap.
//   3. 7O2, DATA_W=7, send 0x7F.
//      -> 7 ones, parity 0, then txd=1 for 2*CLKS_PER_BIT; frame length 11*CLKS_PER_BIT.
//   4. FIFO_DEPTH=4, din_valid held high with distinct bytes.
//      -> exactly 5 accepted (1 popped + 4 queued), din_ready low;
//         re-asserts one edge after the next pop; all bytes emitted in order.
//   5. Assert rst_n low mid-DATA with 3 bytes queued.
//      -> txd=1 asynchronously, fifo_level=0, busy=0; after release, a new byte sends cleanly.
//   6. Push while fifo_level==FIFO_DEPTH-1 on the same edge a pop occurs.
//      -> level unchanged, no byte lost or duplicated.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART datapath: FSM state encoding, parity modes
// and the line levels of start/stop bits.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered full/empty/level flags.
// A push while full or a pop while empty is ignored.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic [LVL_W-1:0]  level_next_s;
    logic              full_r;
    logic              empty_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign do_push_s = push && !full_r;
    assign do_pop_s  = pop && !empty_r;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_next_s = level_r;
        if (do_push_s && !do_pop_s) begin
            level_next_s = level_r + LVL_W'(1);
        end else if (do_pop_s && !do_push_s) begin
            level_next_s = level_r - LVL_W'(1);
        end else begin
            level_next_s = level_r;
        end
    end

    // Pointers and flags; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r <= level_next_s;
            full_r  <= (level_next_s == LVL_W'(DEPTH));
            empty_r <= (level_next_s == {LVL_W{1'b0}});
        end
    end

    // Storage array, no reset needed: contents are only read when valid.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign level = level_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input byte FIFO, internal baud counter and
// configurable data width, parity and stop bits. txd idles high.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    tx_state_e         state_r;
    logic [BAUD_W-1:0] baud_r;
    logic [BIT_W-1:0]  bit_r;
    logic              stop_r;
    logic [DATA_W-1:0] shreg_r;
    logic              par_r;
    logic              txd_r;
    logic              busy_r;

    logic [DATA_W-1:0] fifo_dout_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              push_ok_s;
    logic              pop_s;
    logic              baud_done_s;
    logic              stop_done_s;

    function automatic logic calc_parity(input logic [DATA_W-1:0] d);
        return (PARITY == PAR_ODD) ? ~(^d) : (^d);
    endfunction

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (din_valid),
        .din   (din),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    assign push_ok_s   = din_valid && !fifo_full_s;
    assign baud_done_s = (baud_r == BAUD_LAST);
    assign stop_done_s = (STOP_BITS == 1) || stop_r;
    // Pop from IDLE, or on the final stop cycle so the next start bit follows with no gap.
    assign pop_s = !fifo_empty_s &&
                   ((state_r == ST_IDLE) ||
                    ((state_r == ST_STOP) && baud_done_s && stop_done_s));

    // Frame sequencer: txd and busy are set alongside each state transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            baud_r  <= {BAUD_W{1'b0}};
            bit_r   <= {BIT_W{1'b0}};
            stop_r  <= 1'b0;
            shreg_r <= {DATA_W{1'b0}};
            par_r   <= 1'b0;
            txd_r   <= STOP_BIT;
            busy_r  <= 1'b0;
        end else begin
            busy_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    baud_r <= {BAUD_W{1'b0}};
                    if (pop_s) begin
                        shreg_r <= fifo_dout_s;
                        par_r   <= calc_parity(fifo_dout_s);
                        state_r <= ST_START;
                        txd_r   <= START_BIT;
                    end else begin
                        txd_r  <= STOP_BIT;
                        busy_r <= push_ok_s;
                    end
                end
                ST_START: begin
                    if (baud_done_s) begin
                        baud_r  <= {BAUD_W{1'b0}};
                        bit_r   <= {BIT_W{1'b0}};
                        txd_r   <= shreg_r[0];
                        shreg_r <= {1'b0, shreg_r[DATA_W-1:1]};
                        state_r <= ST_DATA;
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_done_s) begin
                        baud_r <= {BAUD_W{1'b0}};
                        if (bit_r == BIT_LAST) begin
                            if (PARITY != PAR_NONE) begin
                                state_r <= ST_PARITY;
                                txd_r   <= par_r;
                            end else begin
                                state_r <= ST_STOP;
                                txd_r   <= STOP_BIT;
                                stop_r  <= 1'b0;
                            end
                        end else begin
                            bit_r   <= bit_r + BIT_W'(1);
                            txd_r   <= shreg_r[0];
                            shreg_r <= {1'b0, shreg_r[DATA_W-1:1]};
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (baud_done_s) begin
                        baud_r  <= {BAUD_W{1'b0}};
                        state_r <= ST_STOP;
                        txd_r   <= STOP_BIT;
                        stop_r  <= 1'b0;
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_done_s) begin
                        baud_r <= {BAUD_W{1'b0}};
                        if (!stop_done_s) begin
                            stop_r <= 1'b1;
                        end else if (pop_s) begin
                            shreg_r <= fifo_dout_s;
                            par_r   <= calc_parity(fifo_dout_s);
                            state_r <= ST_START;
                            txd_r   <= START_BIT;
                        end else begin
                            state_r <= ST_IDLE;
                            txd_r   <= STOP_BIT;
                            busy_r  <= push_ok_s;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    baud_r  <= {BAUD_W{1'b0}};
                    txd_r   <= STOP_BIT;
                end
            endcase
        end
    end

    assign din_ready = !fifo_full_s;
    assign txd       = txd_r;
    assign busy      = busy_r;

endmodule
